// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter
// Description : Shares one single-port Memory between an instruction-fetch
//               requester (read-only) and a data requester (read/write).
//               Memory signals are registered; read data (1-cycle latency)
//               is routed back to the requester that owns the access.
//               i_halt freezes all progress, since it also gates Memory's clock.
// Ports       : i_clk, i_reset        - clock, async active-high reset
//               i_halt                - freeze; acks/rvalids forced low
//               i_f_* / o_f_*         - fetch request / ack / read response
//               i_d_* / o_d_*         - data request / ack / read response
//               o_mem_* / i_mem_data  - Memory interface
//               o_busy                - arbiter not idle
// Options     : MEMORY_ARBITER_ROUND_ROBIN_EN - round-robin grant on
//               contention; default is fixed priority (data over fetch).
// Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_halt,
    input  logic              i_f_req,
    input  logic [ADDR_W-1:0] i_f_addr,
    output logic              o_f_ack,
    output logic              o_f_rvalid,
    output logic [DATA_W-1:0] o_f_rdata,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic              o_d_ack,
    output logic              o_d_rvalid,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [DATA_W-1:0] o_mem_data,
    output logic              o_mem_re,
    output logic              o_mem_we,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic c_OWN_F = 1'b0;
    localparam logic c_OWN_D = 1'b1;

    state_t            r_state;
    state_t            w_next_state;
    logic              r_owner;
    logic              w_next_owner;
    logic [ADDR_W-1:0] r_mem_address;
    logic [ADDR_W-1:0] w_next_address;
    logic [DATA_W-1:0] r_mem_data;
    logic [DATA_W-1:0] w_next_data;
    logic              r_mem_re;
    logic              w_next_re;
    logic              r_mem_we;
    logic              w_next_we;

    logic              w_cand_f;
    logic              w_cand_d;
    logic              w_grant;
    logic              w_sel_d;
    logic              w_prio_d;
    logic              w_load_we;
    logic              w_ack_edge;

    // An access completes on any non-halted edge spent in ISSUE.
    assign w_ack_edge = (r_state == S_ISSUE) && !i_halt;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    // Last-granted pointer: on contention, favour whoever did not go last.
    logic r_last;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_last <= c_OWN_F;
        end else if (w_ack_edge) begin
            r_last <= r_owner;
        end
    end

    assign w_prio_d = (r_last == c_OWN_F);
`else
    assign w_prio_d = 1'b1;
`endif

    // Candidate requesters for the next grant. After a write completes only
    // the other requester may be loaded: the owner's req still reflects the
    // request being acked on this very edge.
    always_comb begin
        w_cand_f = 1'b0;
        w_cand_d = 1'b0;
        case (r_state)
            S_IDLE, S_RESP: begin
                w_cand_f = i_f_req;
                w_cand_d = i_d_req;
            end
            S_ISSUE: begin
                if (r_mem_we) begin
                    w_cand_f = i_f_req && (r_owner == c_OWN_D);
                    w_cand_d = i_d_req && (r_owner == c_OWN_F);
                end
            end
            default: begin
                w_cand_f = 1'b0;
                w_cand_d = 1'b0;
            end
        endcase
    end

    assign w_grant   = w_cand_f || w_cand_d;
    assign w_sel_d   = w_cand_d && (!w_cand_f || w_prio_d);
    assign w_load_we = w_sel_d && i_d_we;

    // Next-state and next Memory-register values.
    always_comb begin
        w_next_state   = r_state;
        w_next_owner   = r_owner;
        w_next_address = r_mem_address;
        w_next_data    = r_mem_data;
        w_next_re      = r_mem_re;
        w_next_we      = r_mem_we;

        if (!i_halt) begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        w_next_state = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_mem_we) begin
                        if (w_grant) begin
                            w_next_state = S_ISSUE;
                        end else begin
                            w_next_state = S_IDLE;
                            w_next_we    = 1'b0;
                            w_next_re    = 1'b0;
                        end
                    end else begin
                        w_next_state = S_RESP;
                        w_next_re    = 1'b0;
                    end
                end
                S_RESP: begin
                    if (w_grant) begin
                        w_next_state = S_ISSUE;
                    end else begin
                        w_next_state = S_IDLE;
                        w_next_re    = 1'b0;
                        w_next_we    = 1'b0;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                    w_next_re    = 1'b0;
                    w_next_we    = 1'b0;
                end
            endcase

            // Every transition into ISSUE loads the selected winner.
            if (w_grant && (w_next_state == S_ISSUE)) begin
                w_next_owner   = w_sel_d ? c_OWN_D : c_OWN_F;
                w_next_address = w_sel_d ? i_d_addr : i_f_addr;
                w_next_data    = w_sel_d ? i_d_wdata : '0;
                w_next_we      = w_load_we;
                w_next_re      = !w_load_we;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_owner       <= c_OWN_F;
            r_mem_address <= '0;
            r_mem_data    <= '0;
            r_mem_re      <= 1'b0;
            r_mem_we      <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_owner       <= w_next_owner;
            r_mem_address <= w_next_address;
            r_mem_data    <= w_next_data;
            r_mem_re      <= w_next_re;
            r_mem_we      <= w_next_we;
        end
    end

    assign o_mem_address = r_mem_address;
    assign o_mem_data    = r_mem_data;
    assign o_mem_re      = r_mem_re;
    assign o_mem_we      = r_mem_we;

    assign o_f_ack    = w_ack_edge && (r_owner == c_OWN_F);
    assign o_d_ack    = w_ack_edge && (r_owner == c_OWN_D);
    assign o_f_rvalid = (r_state == S_RESP) && !i_halt && (r_owner == c_OWN_F);
    assign o_d_rvalid = (r_state == S_RESP) && !i_halt && (r_owner == c_OWN_D);

    // Only the owner of the response sees Memory data; the other reads 0.
    assign o_f_rdata = ((r_state == S_RESP) && (r_owner == c_OWN_F)) ? i_mem_data : '0;
    assign o_d_rdata = ((r_state == S_RESP) && (r_owner == c_OWN_D)) ? i_mem_data : '0;

    assign o_busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_arbiter
// Description : Self-checking bench for memory_arbiter with a behavioural
//               halt-gated Memory model and a read-data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic        f_req;
    logic [15:0] f_addr;
    logic        f_ack;
    logic        f_rvalid;
    logic [15:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic        d_rvalid;
    logic [15:0] d_rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_re;
    logic        mem_we;
    logic [15:0] mem_rdata;
    logic        busy;

    memory_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_halt        (halt),
        .i_f_req       (f_req),
        .i_f_addr      (f_addr),
        .o_f_ack       (f_ack),
        .o_f_rvalid    (f_rvalid),
        .o_f_rdata     (f_rdata),
        .i_d_req       (d_req),
        .i_d_we        (d_we),
        .i_d_addr      (d_addr),
        .i_d_wdata     (d_wdata),
        .o_d_ack       (d_ack),
        .o_d_rvalid    (d_rvalid),
        .o_d_rdata     (d_rdata),
        .o_mem_address (mem_addr),
        .o_mem_data    (mem_wdata),
        .o_mem_re      (mem_re),
        .o_mem_we      (mem_we),
        .i_mem_data    (mem_rdata),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    // Memory: 256 words, low 8 address bits, registered read, clock gated by halt.
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (!halt) begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
            if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] f_exp_q [$];
    logic [15:0] d_exp_q [$];
    bit          grant_log [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Response monitor: pops the scoreboard on each rvalid, logs grants.
    always @(negedge clk) begin
        if (!rst) begin
            if (f_ack) grant_log.push_back(1'b0);
            if (d_ack) grant_log.push_back(1'b1);
            if (f_rvalid) begin
                if (f_exp_q.size() == 0) check("f_rvalid_unexpected", 1, 0);
                else                     check("f_rdata", f_rdata, f_exp_q.pop_front());
                check("d_rdata_nonowner", d_rdata, 0);
            end
            if (d_rvalid) begin
                if (d_exp_q.size() == 0) check("d_rvalid_unexpected", 1, 0);
                else                     check("d_rdata", d_rdata, d_exp_q.pop_front());
                check("f_rdata_nonowner", f_rdata, 0);
            end
        end
    end

    typedef struct {
        bit          is_d;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    // Caller sits 2 time units after a rising edge; returns at the same phase.
    task automatic do_txn(input vec_t v);
        int waited;
        logic ack_now;
        if (!v.we) begin
            if (v.is_d) d_exp_q.push_back(v.exp_rdata);
            else        f_exp_q.push_back(v.exp_rdata);
        end
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            f_req = 1'b1; f_addr = v.addr;
        end
        @(posedge clk); #2;
        waited = 0;
        ack_now = v.is_d ? d_ack : f_ack;
        while (!ack_now && waited < 8) begin
            @(posedge clk); #2;
            waited++;
            ack_now = v.is_d ? d_ack : f_ack;
        end
        check("ack_latency", waited, 0);
        check("issue_addr", mem_addr, v.addr);
        check("issue_re", mem_re, !v.we);
        check("issue_we", mem_we, v.we);
        check("issue_busy", busy, 1);
        if (v.we) check("issue_wdata", mem_wdata, v.wdata);
        @(posedge clk); #2;
        f_req = 1'b0;
        d_req = 1'b0;
        if (!v.we) begin
            check("rvalid", v.is_d ? d_rvalid : f_rvalid, 1);
            @(posedge clk); #2;
        end
        check("idle_busy", busy, 0);
        check("idle_we", mem_we, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        grant_log.delete();
        @(posedge clk); #2;
    endtask

    initial begin
        rst = 1'b1; halt = 1'b0;
        f_req = 1'b0; f_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
        mem[8'h10] = 16'hBEEF;

        repeat (2) @(posedge clk);
        #2;
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_data", mem_wdata, 0);
        check("rst_re_we", {mem_re, mem_we}, 0);
        check("rst_acks_rvalids", {f_ack, d_ack, f_rvalid, d_rvalid}, 0);
        check("rst_rdata", {f_rdata, d_rdata}, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(posedge clk); #2;

        //            is_d we  addr      wdata     exp_rdata
        vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        vecs[1] = '{1'b1, 1'b1, 16'h0020, 16'h1234, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234};
        vecs[3] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h1234};
        vecs[4] = '{1'b1, 1'b1, 16'h0105, 16'h5A5A, 16'h0000};
        vecs[5] = '{1'b0, 1'b0, 16'h0005, 16'h0000, 16'h5A5A};
        vecs[6] = '{1'b1, 1'b0, 16'h0031, 16'h0000, 16'hA031};
        vecs[7] = '{1'b0, 1'b0, 16'h00FF, 16'h0000, 16'hA0FF};
        for (int i = 0; i < 8; i++) do_txn(vecs[i]);

        // Simultaneous requests: data first, fetch straight from RESP to ISSUE.
        do_reset();
        f_exp_q.push_back(16'hBEEF);
        d_exp_q.push_back(16'hA031);
        f_req = 1'b1; f_addr = 16'h0010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0031;
        @(posedge clk); #2;
        check("cont_d_ack", {d_ack, f_ack}, 2'b10);
        check("cont_d_addr", mem_addr, 16'h0031);
        @(posedge clk); #2;
        d_req = 1'b0;
        check("cont_d_rvalid", d_rvalid, 1);
        @(posedge clk); #2;
        check("cont_f_ack", {d_ack, f_ack}, 2'b01);
        check("cont_no_idle_gap", busy, 1);
        check("cont_f_addr", mem_addr, 16'h0010);
        @(posedge clk); #2;
        f_req = 1'b0;
        check("cont_f_rvalid", f_rvalid, 1);
        @(posedge clk); #2;
        check("cont_idle", busy, 0);
        check("cont_grant_count", grant_log.size(), 2);
        if (grant_log.size() == 2) check("cont_order", {grant_log[0], grant_log[1]}, 2'b10);

        // Halt for 3 cycles during ISSUE of a data read.
        d_exp_q.push_back(16'h1234);
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020;
        @(posedge clk); #2;
        halt = 1'b1;
        #1;
        check("halt_ack_forced", d_ack, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            check("halt_hold_re", mem_re, 1);
            check("halt_hold_addr", mem_addr, 16'h0020);
            check("halt_no_ack", {d_ack, f_ack}, 0);
            check("halt_busy", busy, 1);
        end
        halt = 1'b0;
        #1;
        check("halt_release_ack", d_ack, 1);
        @(posedge clk); #2;
        d_req = 1'b0;
        check("halt_rvalid", d_rvalid, 1);
        @(posedge clk); #2;
        check("halt_idle", busy, 0);

        // Reset during RESP of a fetch read: response must be discarded.
        f_req = 1'b1; f_addr = 16'h0010;
        @(posedge clk); #2;
        check("rmid_ack", f_ack, 1);
        @(posedge clk); #2;
        f_req = 1'b0;
        check("rmid_in_resp", {busy, f_rvalid}, 2'b11);
        rst = 1'b1;
        #1;
        check("rmid_re_we", {mem_re, mem_we}, 0);
        check("rmid_rvalid", f_rvalid, 0);
        check("rmid_busy", busy, 0);
        check("rmid_addr", mem_addr, 0);
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            check("rmid_no_rvalid", {f_rvalid, d_rvalid}, 0);
        end
        do_txn(vecs[0]);

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        // Both held continuously: grants alternate data, fetch, data, fetch.
        begin
            int  fc = 0;
            int  dc = 0;
            bit  drop_f = 1'b0;
            bit  drop_d = 1'b0;
            bit  exp_order [4];
            exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
            do_reset();
            f_exp_q.push_back(16'hBEEF); f_exp_q.push_back(16'hBEEF);
            d_exp_q.push_back(16'hA031); d_exp_q.push_back(16'hA031);
            f_req = 1'b1; f_addr = 16'h0010;
            d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0031;
            for (int c = 0; c < 24; c++) begin
                @(posedge clk); #2;
                if (drop_f) f_req = 1'b0;
                if (drop_d) d_req = 1'b0;
                drop_f = 1'b0;
                drop_d = 1'b0;
                if (!f_req && !d_req) break;
                if (f_ack) begin fc++; if (fc == 2) drop_f = 1'b1; end
                if (d_ack) begin dc++; if (dc == 2) drop_d = 1'b1; end
            end
            f_req = 1'b0;
            d_req = 1'b0;
            repeat (2) @(posedge clk);
            #2;
            check("rr_counts", {fc[7:0], dc[7:0]}, 16'h0202);
            check("rr_grant_count", grant_log.size(), 4);
            if (grant_log.size() == 4)
                for (int i = 0; i < 4; i++) check("rr_order", grant_log[i], exp_order[i]);
            check("rr_idle", busy, 0);
        end
`endif

        check("f_queue_drained", f_exp_q.size(), 0);
        check("d_queue_drained", d_exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
